uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/baud_tick_counter.sv | 38 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings and default timing.
// Used by uart_rx and uart_tx.
package uart_pkg;

  // 25 MHz clock / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage

// File: rtl/baud_tick_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_clear         : force the count back to 0 on the next edge
//   o_mid_tick      : count is at the bit centre, (CLKS_PER_BIT-1)/2
//   o_full_tick     : count is at the last clock of the bit period
// The tick outputs are decodes of the count register itself.
module baud_tick_counter #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_mid_tick,
  output logic o_full_tick
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned MID_CNT  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned FULL_CNT = CLKS_PER_BIT - 1;

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full      = (r_count == CNT_W'(FULL_CNT));
  assign o_full_tick = w_full;
  assign o_mid_tick  = (r_count == CNT_W'(MID_CNT));

  // Free-running period counter with clear and wrap
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || w_full) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit,
// no parity. Start bit is confirmed at its centre; data and stop bits are
// sampled one full bit period apart from there.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_rx           : asynchronous serial line, idle high
//   o_data         : last correctly framed word (held until the next one)
//   o_valid        : one-cycle pulse, o_data just updated
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_busy         : receiver FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 w_rx_s;
  logic                 w_clear;
  logic                 w_sample;
  logic                 w_valid_set;
  logic                 w_ferr_set;
  logic                 w_mid_tick;
  logic                 w_full_tick;
  logic                 w_last_bit;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s     = r_sync2;
  assign w_last_bit = (r_bit_idx == IDX_W'(DATA_BITS - 1));

  baud_tick_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick_counter (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .o_mid_tick  (w_mid_tick),
    .o_full_tick (w_full_tick)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and datapath controls
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_sample     = 1'b0;
    w_valid_set  = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Hold the counter at 0 so START measures from the falling edge
        w_clear = 1'b1;
        if (!w_rx_s) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_mid_tick) begin
          if (!w_rx_s) begin
            // Re-align the counter to the bit centre
            w_clear      = 1'b1;
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_full_tick) begin
          w_sample = 1'b1;
          if (w_last_bit) begin
            w_state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_full_tick) begin
          if (w_rx_s) begin
            w_valid_set  = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // Break condition: wait for the line to return high
        if (w_rx_s) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Shift register (LSB arrives first, so shift right) and bit index
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else if (w_sample) begin
      r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      r_bit_idx <= w_last_bit ? '0 : r_bit_idx + IDX_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= w_valid_set;
      o_frame_err <= w_ferr_set;
      o_busy      <= (w_state_next != ST_IDLE);
      if (w_valid_set) begin
        o_data <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at CLKS_PER_BIT=16, DATA_BITS=8.
module tb_uart_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned DW  = 8;

  logic          i_clk;
  logic          i_reset;
  logic          i_rx;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  logic [DW-1:0] rx_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge
  always @(negedge i_clk) begin
    if (o_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      rx_q.push_back(o_data);
    end
    if (o_frame_err) ferr_cnt++;
    if (o_valid && o_frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  int v0, f0, lat;
  logic [DW-1:0] got_b;
  logic [DW-1:0] exp3 [3];

  initial begin
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;
    i_rx = 1'b1;
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_data",  32'(o_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_ferr",  32'(o_frame_err), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);
    i_reset = 1'b0;
    idle(8);

    // Single frame 0xA5
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    idle(8);
    lat = last_valid_cyc - start_cyc;
    check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("a5_ferr_cnt",  32'(ferr_cnt - f0), 32'd0);
    check("a5_data",      32'(o_data), 32'hA5);
    if (lat < 152 || lat > 156) $display("latency observed %0d clocks", lat);
    check("a5_latency_in_152_156", 32'(lat >= 152 && lat <= 156), 32'd1);
    check("a5_busy_idle", 32'(o_busy), 32'd0);
    rx_q.delete();

    // Back-to-back frames, no idle gap
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(8);
    check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd3);
    check("b2b_ferr_cnt",  32'(ferr_cnt - f0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      got_b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check($sformatf("b2b_byte%0d", i), 32'(got_b), 32'(exp3[i]));
    end
    rx_q.delete();

    // Start-bit glitch of 4 clocks
    v0 = valid_cnt; f0 = ferr_cnt;
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (10) @(negedge i_clk);
    check("glitch_busy",  32'(o_busy), 32'd0);
    idle(40);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_ferr",  32'(ferr_cnt - f0), 32'd0);

    // Framing error followed by break, then a good frame
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0);
    i_rx = 1'b0;
    repeat (100) @(negedge i_clk);
    check("ferr_busy_in_break", 32'(o_busy), 32'd1);
    idle(32);
    check("ferr_cnt",        32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_valid",   32'(valid_cnt - v0), 32'd0);
    check("ferr_data_held",  32'(o_data), 32'h3C);
    send_frame(8'h81, 1'b1);
    idle(8);
    check("after_ferr_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_ferr_data",  32'(o_data), 32'h81);
    check("after_ferr_ferr",  32'(ferr_cnt - f0), 32'd1);
    rx_q.delete();

    // Reset during data bit 4 of 0xC3; the line returns idle with the reset
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    i_rx = 1'b0;
    repeat (CPB / 2) @(negedge i_clk);
    check("rst_mid_busy_before", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    i_rx = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("rst_mid_data", 32'(o_data), 32'h0);
    idle(3 * CPB);
    check("rst_mid_busy_after", 32'(o_busy), 32'd0);
    check("rst_mid_no_valid",   32'(valid_cnt - v0), 32'd0);
    check("rst_mid_no_ferr",    32'(ferr_cnt - f0), 32'd0);
    send_frame(8'h42, 1'b1);
    idle(8);
    check("rst_then_valid", 32'(valid_cnt - v0), 32'd1);
    check("rst_then_data",  32'(o_data), 32'h42);
    rx_q.delete();

    // Serial loopback of 256 sequential bytes, back-to-back
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
    idle(8);
    check("loop_count", 32'(valid_cnt - v0), 32'd256);
    check("loop_ferr",  32'(ferr_cnt - f0), 32'd0);
    for (int b = 0; b < 256; b++) begin
      got_b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check($sformatf("loop_byte%0d", b), 32'(got_b), 32'(b));
    end
    check("valid_ferr_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
